// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader: FSM encoding and the
// default dump-index width.
package regfile_dump_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SEND_A = 2'd2,
    SEND_B = 2'd3
  } state_e;

  localparam int DUMP_IDX_W = 5;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file two entries per pass through both read ports and
// streams every word with its index over a valid/ready interface.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = DUMP_IDX_W,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] readRegA,
  output logic [ADDR_W-1:0] readRegB,
  input  logic [DATA_W-1:0] regA,
  input  logic [DATA_W-1:0] regB,
  output logic [DATA_W-1:0] dumpData,
  output logic [ADDR_W-1:0] dumpIdx,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic              dumpLast,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] PAIR_STEP = ADDR_W'(2);

  state_e            state;
  logic [DATA_W-1:0] buf_a;
  logic [DATA_W-1:0] buf_b;
  logic              send_b;

  // The beat payload is a pure register mux keyed by the registered state, so
  // it is stable for as long as the state holds during a stall.
  assign send_b   = (state == SEND_B);
  assign dumpData = send_b ? buf_b : buf_a;
  assign dumpIdx  = send_b ? readRegB : readRegA;

  // NOTE: sequential state uses non-blocking assignments only, so every branch
  // below sees the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      readRegA  <= '0;
      readRegB  <= '0;
      buf_a     <= '0;
      buf_b     <= '0;
      dumpValid <= 1'b0;
      dumpLast  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old dump.
          if (start && !done) begin
            state    <= ISSUE;
            readRegA <= '0;
            readRegB <= ADDR_W'(1);
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          // The regfile drove regA/regB on this cycle's negedge.
          buf_a     <= regA;
          buf_b     <= regB;
          dumpValid <= 1'b1;
          dumpLast  <= 1'b0;
          state     <= SEND_A;
        end
        SEND_A: begin
          if (dumpReady) begin
            dumpLast <= (readRegB == LAST_IDX);
            state    <= SEND_B;
          end
        end
        SEND_B: begin
          if (dumpReady) begin
            dumpValid <= 1'b0;
            dumpLast  <= 1'b0;
            if (dumpLast) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              readRegA <= readRegA + PAIR_STEP;
              readRegB <= readRegB + PAIR_STEP;
              state    <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dumps, backpressure, ignored
// starts, mid-dump reset, a 4-register instance and a long stall.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  readRegA, readRegB;
  logic [31:0] regA, regB;
  logic [31:0] dumpData;
  logic [4:0]  dumpIdx;
  logic        dumpValid, dumpReady, dumpLast, busy, done;

  logic        start4;
  logic [1:0]  readRegA4, readRegB4;
  logic [31:0] regA4, regB4;
  logic [31:0] dumpData4;
  logic [1:0]  dumpIdx4;
  logic        dumpValid4, dumpReady4, dumpLast4, busy4, done4;

  logic [31:0] mem  [32];
  logic [31:0] mem4 [4];

  int tests_run;
  int tests_failed;

  // Results collected by dump32
  int          nbeats, viol, done_cnt, done_cyc, last_cnt, last_idx, held, post_busy;
  bit          timeout;
  int          got_idx  [64];
  logic [31:0] got_data [64];

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .readRegA(readRegA), .readRegB(readRegB), .regA(regA), .regB(regB),
    .dumpData(dumpData), .dumpIdx(dumpIdx), .dumpValid(dumpValid),
    .dumpReady(dumpReady), .dumpLast(dumpLast), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.NUM_REGS(4), .ADDR_W(2), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .readRegA(readRegA4), .readRegB(readRegB4), .regA(regA4), .regB(regB4),
    .dumpData(dumpData4), .dumpIdx(dumpIdx4), .dumpValid(dumpValid4),
    .dumpReady(dumpReady4), .dumpLast(dumpLast4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile read ports update on the falling edge.
  always @(negedge clk) begin
    regA  <= mem[readRegA];
    regB  <= mem[readRegB];
    regA4 <= mem4[readRegA4];
    regB4 <= mem4[readRegB4];
  end

  task automatic dump32(input bit rand_ready, input int restart_at, input int stall_idx,
                        input int stall_len, input bit poke_at_done);
    bit          seen_done;
    logic        pv, phs, pl;
    logic [31:0] pd;
    logic [4:0]  pi;
    int          stall_cnt;
    nbeats = 0; viol = 0; done_cnt = 0; done_cyc = -1; last_cnt = 0; last_idx = -1;
    held = 0; post_busy = 0; timeout = 1'b0; seen_done = 1'b0;
    pv = 1'b0; phs = 1'b0; pl = 1'b0; pd = '0; pi = '0; stall_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    dumpReady = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (pv && !phs && (!dumpValid || dumpData !== pd || dumpIdx !== pi || dumpLast !== pl))
        viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dumpValid && dumpIdx == 5'(stall_idx)) held++;
      if (dumpValid && stall_len > 0 && dumpIdx == 5'(stall_idx) && stall_cnt < stall_len) begin
        dumpReady = 1'b0;
        stall_cnt++;
      end else if (rand_ready) begin
        dumpReady = 1'($urandom_range(0, 1));
      end else begin
        dumpReady = 1'b1;
      end
      if (dumpValid && dumpReady) begin
        if (nbeats < 64) begin
          got_idx[nbeats]  = int'(dumpIdx);
          got_data[nbeats] = dumpData;
        end
        if (dumpLast) begin
          last_cnt++;
          last_idx = int'(dumpIdx);
        end
        nbeats++;
      end
      pv = dumpValid; phs = dumpValid && dumpReady;
      pd = dumpData; pi = dumpIdx; pl = dumpLast;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
    end
    if (!seen_done) timeout = 1'b1;
    if (poke_at_done) start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || dumpValid || done) post_busy++;
    end
  endtask

  function automatic int order_errors(input int n);
    int bad = 0;
    for (int i = 0; i < n && i < 64; i++)
      if (got_idx[i] !== i || got_data[i] !== 32'h100 + 32'(i)) bad++;
    return bad;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({readRegA, readRegB, dumpData, dumpIdx, dumpValid, dumpLast, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got readA=%0d readB=%0d data=%h idx=%0d v=%b l=%b busy=%b done=%b, expected all 0",
               readRegA, readRegB, dumpData, dumpIdx, dumpValid, dumpLast, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_dump;
    int bad;
    dump32(1'b0, -1, -1, 0, 1'b0);
    bad = order_errors(nbeats);
    tests_run += 6;
    if (timeout !== 1'b0) begin tests_failed++; $display("FAIL full_timeout: no done within budget"); end
    if (nbeats !== 32) begin tests_failed++; $display("FAIL full_beats: got %0d expected 32", nbeats); end
    if (bad !== 0) begin tests_failed++; $display("FAIL full_order: %0d beats wrong, expected 0", bad); end
    if (last_cnt !== 1 || last_idx !== 31) begin
      tests_failed++; $display("FAIL full_last: count %0d idx %0d, expected 1 at 31", last_cnt, last_idx);
    end
    if (done_cnt !== 1 || done_cyc !== 48) begin
      tests_failed++; $display("FAIL full_done: count %0d cycle %0d, expected 1 at 48", done_cnt, done_cyc);
    end
    if (post_busy !== 0) begin tests_failed++; $display("FAIL full_idle_after: %0d active cycles, expected 0", post_busy); end
  endtask

  task automatic test_backpressure;
    int bad;
    dump32(1'b1, -1, -1, 0, 1'b0);
    bad = order_errors(nbeats);
    tests_run += 4;
    if (nbeats !== 32) begin tests_failed++; $display("FAIL bp_beats: got %0d expected 32", nbeats); end
    if (bad !== 0) begin tests_failed++; $display("FAIL bp_order: %0d beats wrong, expected 0", bad); end
    if (viol !== 0) begin tests_failed++; $display("FAIL bp_stability: %0d violations, expected 0", viol); end
    if (done_cnt !== 1 || last_idx !== 31) begin
      tests_failed++; $display("FAIL bp_done: done %0d last idx %0d, expected 1 and 31", done_cnt, last_idx);
    end
  endtask

  task automatic test_start_while_busy;
    dump32(1'b0, 10, -1, 0, 1'b1);
    tests_run += 3;
    if (nbeats !== 32) begin tests_failed++; $display("FAIL restart_beats: got %0d expected 32", nbeats); end
    if (done_cnt !== 1 || done_cyc !== 48) begin
      tests_failed++; $display("FAIL restart_done: count %0d cycle %0d, expected 1 at 48", done_cnt, done_cyc);
    end
    if (post_busy !== 0) begin tests_failed++; $display("FAIL start_at_done: %0d active cycles, expected 0", post_busy); end
  endtask

  task automatic test_reset_mid_dump;
    bit found = 1'b0;
    int saw_done = 0;
    @(negedge clk);
    start = 1'b1;
    dumpReady = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (dumpValid && dumpIdx == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL rst_mid_reach: beat idx 7 never seen"); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({readRegA, readRegB, dumpData, dumpIdx, dumpValid, dumpLast, busy, done} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: data=%h idx=%0d v=%b l=%b busy=%b, expected all 0",
               dumpData, dumpIdx, dumpValid, dumpLast, busy);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    tests_run++;
    if (saw_done !== 0) begin tests_failed++; $display("FAIL rst_mid_no_done: %0d cycles active, expected 0", saw_done); end
    dump32(1'b0, -1, -1, 0, 1'b0);
    tests_run += 2;
    if (nbeats !== 32 || got_idx[0] !== 0) begin
      tests_failed++; $display("FAIL rst_redump: beats %0d first idx %0d, expected 32 from 0", nbeats, got_idx[0]);
    end
    if (order_errors(nbeats) !== 0) begin tests_failed++; $display("FAIL rst_redump_order: beats out of order"); end
  endtask

  task automatic test_small_regs;
    int n = 0, bad = 0, lasts = 0, dcyc = -1;
    @(negedge clk);
    start4 = 1'b1;
    dumpReady4 = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (dumpValid4 && dumpReady4) begin
        if (int'(dumpIdx4) !== n || dumpData4 !== mem4[n % 4]) bad++;
        if (dumpLast4) begin
          lasts++;
          if (dumpIdx4 !== 2'd3) bad++;
        end
        n++;
      end
      if (done4) begin
        dcyc = cyc;
        break;
      end
    end
    tests_run += 3;
    if (n !== 4 || bad !== 0) begin tests_failed++; $display("FAIL small_beats: %0d beats %0d wrong, expected 4 and 0", n, bad); end
    if (lasts !== 1) begin tests_failed++; $display("FAIL small_last: %0d last beats, expected 1", lasts); end
    if (dcyc !== 6) begin tests_failed++; $display("FAIL small_done: cycle %0d expected 6", dcyc); end
  endtask

  task automatic test_long_stall;
    dump32(1'b0, -1, 30, 20, 1'b0);
    tests_run += 4;
    if (held !== 21) begin tests_failed++; $display("FAIL stall_held: idx 30 visible %0d cycles, expected 21", held); end
    if (viol !== 0) begin tests_failed++; $display("FAIL stall_stability: %0d violations, expected 0", viol); end
    if (nbeats !== 32 || last_idx !== 31) begin
      tests_failed++; $display("FAIL stall_beats: %0d beats last %0d, expected 32 and 31", nbeats, last_idx);
    end
    if (done_cnt !== 1 || done_cyc !== 68) begin
      tests_failed++; $display("FAIL stall_done: count %0d cycle %0d, expected 1 at 68", done_cnt, done_cyc);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    start = 1'b0; dumpReady = 1'b0;
    start4 = 1'b0; dumpReady4 = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
    for (int i = 0; i < 4; i++) mem4[i] = 32'hCAFE_00A0 + 32'(i);
    test_reset;
    test_full_dump;
    test_backpressure;
    test_start_while_busy;
    test_reset_mid_dump;
    test_small_regs;
    test_long_stall;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
